// File: rtl/log.sv
// Trace capture buffer: a circular store of WIDTH-bit words, drained over a PCIe-style AR/R burst port.
// Optional dropped-write counter on pci_rdata[511:480] when LOG_OVERFLOW_CNT_EN is defined.
module log #(
    parameter int WIDTH     = 64,
    parameter int LOG_DEPTH = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wvalid,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pci_arvalid,
    output logic                 pci_arready,
    input  logic [31:0]          pci_araddr,
    input  logic [7:0]           pci_arlen,
    output logic                 pci_rvalid,
    input  logic                 pci_rready,
    output logic [511:0]         pci_rdata,
    output logic                 pci_rlast,
    output logic [LOG_DEPTH:0]   size
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int                   DEPTH     = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH:0]   FULL_SIZE = {1'b1, {LOG_DEPTH{1'b0}}};
    localparam logic [LOG_DEPTH:0]   SIZE_ONE  = (LOG_DEPTH + 1)'(1);
    localparam logic [LOG_DEPTH-1:0] PTR_ONE   = LOG_DEPTH'(1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [LOG_DEPTH-1:0] head_q;
    logic [LOG_DEPTH-1:0] tail_q;
    logic [LOG_DEPTH:0]   size_q;
    logic [LOG_DEPTH:0]   size_d;
    state_e               state_q;
    logic [7:0]           beat_cnt_q;
    logic                 arready_q;
    logic                 rvalid_q;
    logic                 rlast_q;
    logic                 empty_q;
    logic                 full_s;
    logic                 wr_s;
    logic                 hs_s;
    logic                 pop_s;
    logic                 unused_araddr_s;

    assign unused_araddr_s = ^pci_araddr;

    // Write/pop qualification and occupancy next-state; fullness uses the start-of-cycle size.
    always_comb begin
        full_s = (size_q == FULL_SIZE);
        wr_s   = wvalid && !full_s;
        hs_s   = rvalid_q && pci_rready;
        pop_s  = hs_s && !empty_q;
        size_d = size_q;
        if (wr_s && !pop_s) begin
            size_d = size_q + SIZE_ONE;
        end else if (pop_s && !wr_s) begin
            size_d = size_q - SIZE_ONE;
        end else begin
            size_d = size_q;
        end
    end

    // Head/tail pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
            size_q <= '0;
        end else begin
            if (wr_s) begin
                tail_q <= tail_q + PTR_ONE;
            end
            if (pop_s) begin
                head_q <= head_q + PTR_ONE;
            end
            size_q <= size_d;
        end
    end

    // Trace storage; contents are meaningless until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[tail_q] <= wdata;
        end
    end

    // Read FSM. empty_q freezes whether the presented beat is a zero beat, so a write
    // landing in an empty buffer during a stall cannot disturb the held rdata.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            beat_cnt_q <= 8'd0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pci_arvalid) begin
                        state_q    <= BURST;
                        beat_cnt_q <= pci_arlen;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rlast_q    <= (pci_arlen == 8'd0);
                        empty_q    <= (size_d == '0);
                    end
                end
                BURST: begin
                    if (hs_s) begin
                        if (beat_cnt_q == 8'd0) begin
                            state_q   <= IDLE;
                            arready_q <= 1'b1;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            empty_q   <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q - 8'd1;
                            rlast_q    <= (beat_cnt_q == 8'd1);
                            empty_q    <= (size_d == '0);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                    rlast_q   <= 1'b0;
                    empty_q   <= 1'b1;
                end
            endcase
        end
    end

`ifdef LOG_OVERFLOW_CNT_EN
    logic [31:0] ovf_q;

    // Saturating count of writes dropped because the buffer was full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 32'd0;
        end else if (wvalid && full_s && (ovf_q != 32'hFFFF_FFFF)) begin
            ovf_q <= ovf_q + 32'd1;
        end
    end
`endif

    // Beat data: head entry zero-extended, or zero for a beat issued against an empty buffer.
    always_comb begin
        pci_rdata = '0;
        if (!empty_q) begin
            pci_rdata[WIDTH-1:0] = mem_q[head_q];
        end else begin
            pci_rdata[WIDTH-1:0] = '0;
        end
`ifdef LOG_OVERFLOW_CNT_EN
        pci_rdata[511:480] = ovf_q;
`endif
    end

    assign pci_arready = arready_q;
    assign pci_rvalid  = rvalid_q;
    assign pci_rlast   = rlast_q;
    assign size        = size_q;

endmodule

// File: tb/tb_log.sv
// Directed self-checking bench for log (WIDTH=16, LOG_DEPTH=2); follows LOG_OVERFLOW_CNT_EN if defined.
module tb_log;

    localparam int W  = 16;
    localparam int LD = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wvalid = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          pci_arvalid = 1'b0;
    logic          pci_arready;
    logic [31:0]   pci_araddr = 32'h0000_1000;
    logic [7:0]    pci_arlen = 8'd0;
    logic          pci_rvalid;
    logic          pci_rready = 1'b0;
    logic [511:0]  pci_rdata;
    logic          pci_rlast;
    logic [LD:0]   size;

    int checks = 0;
    int failures = 0;
    int unsigned drops_exp = 0;

    log #(.WIDTH(W), .LOG_DEPTH(LD)) dut (
        .clk(clk), .rstn(rstn), .wvalid(wvalid), .wdata(wdata),
        .pci_arvalid(pci_arvalid), .pci_arready(pci_arready),
        .pci_araddr(pci_araddr), .pci_arlen(pci_arlen),
        .pci_rvalid(pci_rvalid), .pci_rready(pci_rready),
        .pci_rdata(pci_rdata), .pci_rlast(pci_rlast), .size(size)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] beat_exp(input logic [W-1:0] w);
        logic [511:0] e;
        e = '0;
        e[W-1:0] = w;
`ifdef LOG_OVERFLOW_CNT_EN
        e[511:480] = drops_exp;
`endif
        return e;
    endfunction

    task automatic write_words(input logic [W-1:0] ws[], input int n);
        for (int i = 0; i < n; i++) begin
            wvalid = 1'b1;
            wdata = ws[i];
            tick();
        end
        wvalid = 1'b0;
    endtask

    task automatic start_burst(input logic [7:0] len, input logic rdy);
        pci_arvalid = 1'b1;
        pci_arlen = len;
        pci_rready = rdy;
        tick();
        pci_arvalid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (pci_rvalid !== 1'b0 || pci_rlast !== 1'b0 || size !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs rvalid=%b rlast=%b size=%0d want 0/0/0", pci_rvalid, pci_rlast, size);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        checks++;
        if (pci_arready !== 1'b1) begin
            failures++;
            $display("FAIL reset_arready got=%b want 1", pci_arready);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] ws[] = '{16'h0011, 16'h0022, 16'h0033};
        write_words(ws, 3);
        checks++;
        if (size !== 3'd3) begin failures++; $display("FAIL basic_size_fill got=%0d want 3", size); end
        start_burst(8'd2, 1'b1);
        checks++;
        if (pci_arready !== 1'b0) begin failures++; $display("FAIL basic_arready_burst got=%b want 0", pci_arready); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pci_rvalid !== 1'b1 || pci_rdata !== beat_exp(ws[i]) || pci_rlast !== (i == 2) || size !== 3'(3 - i)) begin
                failures++;
                $display("FAIL basic_beat%0d rvalid=%b rdata=%h rlast=%b size=%0d want 1 %h %b %0d",
                         i, pci_rvalid, pci_rdata, pci_rlast, size, beat_exp(ws[i]), (i == 2), 3 - i);
            end
            tick();
        end
        checks++;
        if (pci_rvalid !== 1'b0 || size !== 3'd0 || pci_arready !== 1'b1) begin
            failures++;
            $display("FAIL basic_end rvalid=%b size=%0d arready=%b want 0 0 1", pci_rvalid, size, pci_arready);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] ws[] = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5, 16'h00A6};
        write_words(ws, 6);
        drops_exp = 2;
        checks++;
        if (size !== 3'd4) begin failures++; $display("FAIL ovf_size got=%0d want 4", size); end
        start_burst(8'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pci_rdata !== beat_exp(ws[i]) || pci_rlast !== (i == 3)) begin
                failures++;
                $display("FAIL ovf_beat%0d rdata=%h rlast=%b want %h %b", i, pci_rdata, pci_rlast, beat_exp(ws[i]), (i == 3));
            end
            tick();
        end
        checks++;
        if (size !== 3'd0 || pci_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_end size=%0d rvalid=%b want 0 0", size, pci_rvalid);
        end
    endtask

    task automatic test_full_pop();
        logic [W-1:0] ws[] = '{16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4};
        write_words(ws, 4);
        start_burst(8'd0, 1'b1);
        checks++;
        if (pci_rdata !== beat_exp(16'h00B1) || pci_rlast !== 1'b1) begin
            failures++;
            $display("FAIL fullpop_beat rdata=%h rlast=%b want %h 1", pci_rdata, pci_rlast, beat_exp(16'h00B1));
        end
        wvalid = 1'b1;
        wdata = 16'h00B5;
        tick();
        wvalid = 1'b0;
        drops_exp = 3;
        checks++;
        if (size !== 3'd3 || pci_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_size size=%0d rvalid=%b want 3 0", size, pci_rvalid);
        end
        start_burst(8'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pci_rdata !== beat_exp(ws[i + 1])) begin
                failures++;
                $display("FAIL fullpop_drain%0d rdata=%h want %h", i, pci_rdata, beat_exp(ws[i + 1]));
            end
            tick();
        end
        checks++;
        if (size !== 3'd0) begin failures++; $display("FAIL fullpop_end size=%0d want 0", size); end
    endtask

    task automatic test_empty();
        start_burst(8'd1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pci_rvalid !== 1'b1 || pci_rdata !== beat_exp(16'h0000) || pci_rlast !== (i == 1) || size !== 3'd0) begin
                failures++;
                $display("FAIL empty_beat%0d rvalid=%b rdata=%h rlast=%b size=%0d want 1 %h %b 0",
                         i, pci_rvalid, pci_rdata, pci_rlast, size, beat_exp(16'h0000), (i == 1));
            end
            tick();
        end
        checks++;
        if (pci_rvalid !== 1'b0 || size !== 3'd0) begin
            failures++;
            $display("FAIL empty_end rvalid=%b size=%0d want 0 0", pci_rvalid, size);
        end
        start_burst(8'd1, 1'b1);
        wvalid = 1'b1;
        wdata = 16'h00D1;
        tick();
        wvalid = 1'b0;
        checks++;
        if (pci_rdata !== beat_exp(16'h00D1) || pci_rlast !== 1'b1 || size !== 3'd1) begin
            failures++;
            $display("FAIL empty_write_beat rdata=%h rlast=%b size=%0d want %h 1 1", pci_rdata, pci_rlast, size, beat_exp(16'h00D1));
        end
        tick();
        checks++;
        if (size !== 3'd0) begin failures++; $display("FAIL empty_write_end size=%0d want 0", size); end
    endtask

    task automatic test_write_pop();
        logic [W-1:0] ws[] = '{16'h00C1};
        write_words(ws, 1);
        start_burst(8'd1, 1'b1);
        checks++;
        if (pci_rdata !== beat_exp(16'h00C1) || size !== 3'd1) begin
            failures++;
            $display("FAIL wpop_first rdata=%h size=%0d want %h 1", pci_rdata, size, beat_exp(16'h00C1));
        end
        wvalid = 1'b1;
        wdata = 16'h00C2;
        tick();
        wvalid = 1'b0;
        checks++;
        if (size !== 3'd1 || pci_rdata !== beat_exp(16'h00C2) || pci_rlast !== 1'b1) begin
            failures++;
            $display("FAIL wpop_second size=%0d rdata=%h rlast=%b want 1 %h 1", size, pci_rdata, pci_rlast, beat_exp(16'h00C2));
        end
        tick();
        checks++;
        if (size !== 3'd0 || pci_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL wpop_end size=%0d rvalid=%b want 0 0", size, pci_rvalid);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] ws[] = '{16'h00E1, 16'h00E2, 16'h00E3};
        write_words(ws, 3);
        start_burst(8'd2, 1'b1);
        tick();
        pci_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pci_rvalid !== 1'b1 || pci_rdata !== beat_exp(16'h00E2) || size !== 3'd2 || pci_rlast !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d rvalid=%b rdata=%h size=%0d rlast=%b want 1 %h 2 0",
                         i, pci_rvalid, pci_rdata, size, pci_rlast, beat_exp(16'h00E2));
            end
        end
        pci_rready = 1'b1;
        tick();
        checks++;
        if (pci_rdata !== beat_exp(16'h00E3) || pci_rlast !== 1'b1 || size !== 3'd1) begin
            failures++;
            $display("FAIL stall_last rdata=%h rlast=%b size=%0d want %h 1 1", pci_rdata, pci_rlast, size, beat_exp(16'h00E3));
        end
        tick();
        checks++;
        if (size !== 3'd0 || pci_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL stall_end size=%0d rvalid=%b want 0 0", size, pci_rvalid);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [W-1:0] ws[] = '{16'h00F1, 16'h00F2};
        write_words(ws, 2);
        start_burst(8'd3, 1'b0);
        checks++;
        if (pci_rvalid !== 1'b1) begin failures++; $display("FAIL rstmid_inburst rvalid=%b want 1", pci_rvalid); end
        #2;
        rstn = 1'b0;
        #1;
        drops_exp = 0;
        checks++;
        if (pci_rvalid !== 1'b0 || size !== 3'd0 || pci_rlast !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async rvalid=%b size=%0d rlast=%b want 0 0 0", pci_rvalid, size, pci_rlast);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        start_burst(8'd1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pci_rdata !== beat_exp(16'h0000) || pci_rlast !== (i == 1) || size !== 3'd0) begin
                failures++;
                $display("FAIL rstmid_beat%0d rdata=%h rlast=%b size=%0d want %h %b 0",
                         i, pci_rdata, pci_rlast, size, beat_exp(16'h0000), (i == 1));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_empty();
        test_write_pop();
        test_stall();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/log.md
LOG -- requirements
Module: log

Interface
REQ-001 SHALL have parameter WIDTH, default 64: trace word width in bits, 1..480.
REQ-002 SHALL have parameter LOG_DEPTH, default 10: buffer depth is 2**LOG_DEPTH entries.
REQ-003 SHALL have one clock and an asynchronous active-low reset, with ports: clk input 1 (clock); rstn input 1 (reset).
REQ-004 SHALL have ports: wvalid input 1 (capture request); wdata input WIDTH (trace word).
REQ-005 SHALL have ports: pci_arvalid input 1; pci_arready output 1; pci_araddr input 32 (ignored); pci_arlen input 8 (beats minus one).
REQ-006 SHALL have ports: pci_rvalid output 1; pci_rready input 1; pci_rdata output 512; pci_rlast output 1.
REQ-007 SHALL have port size output LOG_DEPTH+1: current occupancy, 0..2**LOG_DEPTH.

Function
REQ-008 SHALL store trace words in a circular buffer with head/tail pointers that wrap modulo 2**LOG_DEPTH.
REQ-009 SHALL append wdata at tail on any rising edge with wvalid=1 and size<2**LOG_DEPTH, no handshake.
REQ-010 SHALL silently drop a write when full; fullness is evaluated at the start of the cycle, so a same-cycle pop does not admit the write.
REQ-011 SHALL run the read FSM with states IDLE, BURST.
- IDLE: pci_arready=1.
- On pci_arvalid: latch arlen into a beat counter and go to BURST.
REQ-012 SHALL, in BURST, assert pci_rvalid from the cycle after AR acceptance until the final beat handshakes, then return to IDLE (arready low throughout BURST).
REQ-013 SHALL drive pci_rdata[WIDTH-1:0] with the head entry, zero-extended, and hold it stable while pci_rvalid=1 and pci_rready=0.
REQ-014 SHALL pop one entry per beat handshake (pci_rvalid and pci_rready) when non-empty; if empty, the beat returns rdata[WIDTH-1:0]=0 and pops nothing.
REQ-015 SHALL assert pci_rlast on beat arlen+1 only; every burst returns exactly arlen+1 beats, regardless of occupancy.
REQ-016 SHALL keep size unchanged on a simultaneous accepted write and pop.
REQ-017 SHALL accept a write to an empty buffer in the same cycle a zero beat is returned; that word is read on a later beat.
REQ-018 SHALL update size in the cycle after the causing edge (registered output).

Reset
REQ-019 SHALL, while rstn=0, asynchronously clear head, tail and size to 0, FSM to IDLE, and pci_rvalid and pci_rlast to 0; pci_arready is 1 once out of reset.
REQ-020 SHALL abandon an in-progress burst on reset mid-burst, discard all buffer contents, and need no buffer RAM initialisation.

Configuration
REQ-021 SHALL, with macro LOG_OVERFLOW_CNT_EN defined, keep a 32-bit saturating counter of dropped writes (reset 0), driven on pci_rdata[511:480] of every beat.
REQ-022 SHALL, without LOG_OVERFLOW_CNT_EN, drive pci_rdata[511:WIDTH] as zero and implement no counter logic.

Verification
REQ-023 SHALL check: write 0x11,0x22,0x33; arlen=2 -> beats 0x11,0x22,0x33, rlast on third, size 3->0.
REQ-024 SHALL check: LOG_DEPTH=2, write 6 words -> size=4; first four words retained; with macro, rdata[511:480]=2.
REQ-025 SHALL check: empty buffer, arlen=1 -> two beats of rdata=0, rlast on second, size stays 0.
REQ-026 SHALL check: one stored word; write while popping it -> size stays 1; next beat returns new word.
REQ-027 SHALL check: rready held low 3 cycles mid-burst -> rdata stable, no pop, size constant.
REQ-028 SHALL check: rstn low mid-burst -> rvalid=0, size=0 immediately; next burst after reset returns zeros.
